vga_hex_writer: RTL and testbench
=================================

# vga_hex_writer

Write-side sequencer for the VGA text buffer. On a start pulse it snapshots a set of 32-bit words and streams each one into the character buffer write port as 8 uppercase ASCII hex digits, one character per clock. It drives the same `wen` / `w_addr[11:0]` / `w_data[7:0]` port that the text display consumes, so debug values (CSRs, counters, bus probes) can be rendered without a full debugger. The text buffer is 80×30; each cell address is `row*COLS + col`.

## Interface
- `NUM_WORDS`, 8: number of 32-bit words rendered per pass (1..30).
- `ROW0`, 2: text row of word 0.
- `COL0`, 4: column of the first (most significant) digit of each word.
- `ROW_STRIDE`, 1: row spacing between consecutive words (≥1).
- `COLS`, 80: characters per text row.
- `clk`  in  1: system clock (100 MHz domain, same as the text buffer write port).
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `start`  in  1: single-cycle request to render all words; honoured only in IDLE.
- `words`  in  32*NUM_WORDS: word i = `words[i*32+31 -: 32]`.
- `busy`  out  1: high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1: one-cycle pulse after the last character is written.
- `display_wen`  out  1: text buffer write enable.
- `display_w_addr`  out  12: text buffer cell address.
- `display_w_data`  out  8: ASCII character.

## Operation
- Legal configuration: `(ROW0+(NUM_WORDS-1)*ROW_STRIDE)*COLS + COL0 + 7 < 2400`. This is checked at elaboration; an out-of-range configuration is a fatal error.
- State machine: IDLE → WRITE → DONE → IDLE.
- IDLE: when `start=1`, latch all `words` into a snapshot register, load address `ROW0*COLS+COL0`, clear the word index i and nibble index n, then go to WRITE. Later changes to `words` do not affect the pass.
- WRITE: each cycle writes one character.
  - `display_wen=1`.
  - `display_w_addr` = current address.
  - `display_w_data` = ASCII of snapshot word i, nibble `7-n` (MSB first).
  - ASCII mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Address update:
  - n<7: address +1.
  - n=7: address += `ROW_STRIDE*COLS - 7`, and i increments.
  - The update is incremental; no multiplier in the datapath.
- After i=NUM_WORDS-1, n=7: go to DONE.
- DONE: `done=1`, `busy=1`, `display_wen=0` for one cycle, then IDLE.
- `start` outside IDLE (WRITE or DONE) is ignored and not queued.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `display_wen=0`, `display_w_addr=0`, `display_w_data=0`.
- Start sampled at cycle 0 (IDLE). Writes occupy cycles 1..8*NUM_WORDS. `done` is asserted in cycle 8*NUM_WORDS+1.
- `busy` is high in cycles 1..8*NUM_WORDS+1.
- Throughput: 8*NUM_WORDS+2 cycles per pass minimum; the next start is accepted in the cycle after DONE.
- `display_wen` is high only in WRITE.
- `display_w_addr` and `display_w_data` are don't-care when `display_wen=0`, but hold their last values (no toggling).
- Reset mid-pass: the next cycle is in IDLE with all outputs at reset values. No further writes and no `done` pulse. Partially written characters stay in the buffer.
- `start` and `rst` together: `rst` wins.

## Test plan
- Config NUM_WORDS=2, ROW0=2, COL0=4, COLS=80, ROW_STRIDE=1; word0=0x1234ABCD, word1=0xDEADBEEF; start at cycle 0:
  - Cycles 1–8 write addrs 164–171 with 31 32 33 34 41 42 43 44.
  - Cycles 9–16 write addrs 244–251 with 44 45 41 44 42 45 45 46.
  - `done=1` and `wen=0` at cycle 17; `busy=0` at cycle 18.
- Snapshot: same setup, change word0 to 0xFFFFFFFF at cycle 2 → characters are still 0x1234ABCD digits; no 0x46 appears in addrs 164–171.
- Start during WRITE (cycle 5) and during DONE (cycle 17) → exactly 16 writes and one `done` pulse. A start at cycle 18 begins a new pass with its first write at cycle 19.
- `rst` asserted at cycle 5 → cycle 6 has `wen=0`, `busy=0`, addr=0. `done` never pulses. A start at cycle 7 restarts from addr 164.
- All-nibble coverage: word0=0x01234567, word1=0x89ABCDEF, ROW_STRIDE=2 → data 30–37 at 164–171 and 38 39 41–46 at 324–331.
- After reset with no start, 100 idle cycles → `wen`, `busy`, `done` all stay 0.

Source files
------------

// File: rtl/vga_hex_writer_if.sv
// Text-buffer write port: one character cell written per clock when wen is high.
interface vga_hex_writer_if;
  logic        wen;
  logic [11:0] w_addr;
  logic [7:0]  w_data;

  modport master (output wen, w_addr, w_data);
  modport slave  (input  wen, w_addr, w_data);
endinterface

// File: rtl/vga_hex_writer.sv
// Renders NUM_WORDS snapshot words as 8 hex digits each into the text buffer, one char/clock.
// First write one cycle after start; 8*NUM_WORDS+2 cycles per pass; no backpressure, start ignored while busy.
module vga_hex_writer #(
  parameter int NUM_WORDS  = 8,
  parameter int ROW0       = 2,
  parameter int COL0       = 4,
  parameter int ROW_STRIDE = 1,
  parameter int COLS       = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [32*NUM_WORDS-1:0] words,
  output logic                    busy,
  output logic                    done,
  vga_hex_writer_if.master        display
);

  localparam int IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LAST_CELL = (ROW0 + (NUM_WORDS - 1) * ROW_STRIDE) * COLS + COL0 + 7;
  localparam logic [11:0]   BASE_ADDR = 12'(ROW0 * COLS + COL0);
  localparam logic [11:0]   ROW_STEP  = 12'(ROW_STRIDE * COLS - 7);
  localparam logic [IW-1:0] LAST_I    = IW'(NUM_WORDS - 1);

  if (LAST_CELL >= 2400 || NUM_WORDS < 1 || NUM_WORDS > 30 || ROW_STRIDE < 1) begin : g_bad_cfg
    $fatal(1, "vga_hex_writer: configuration does not fit the 80x30 text buffer");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx, idx_p1;
  logic [2:0]    nib, nib_nx, nib_p1;
  logic [11:0]   addr_nx;
  logic [7:0]    data_nx;
  logic          wen_nx, busy_nx, done_nx, snap_ld;
  logic [31:0]   snap [NUM_WORDS];
  logic [31:0]   cur_sh, nxt_word;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  assign idx_p1   = idx + 1'b1;
  assign nib_p1   = nib + 1'b1;
  // Next digit of the current word lands in the top nibble after the shift.
  assign cur_sh   = snap[idx] << {nib_p1, 2'b00};
  assign nxt_word = snap[idx_p1];

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    nib_nx   = nib;
    addr_nx  = display.w_addr;
    data_nx  = display.w_data;
    wen_nx   = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    snap_ld  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          snap_ld  = 1'b1;
          state_nx = S_WRITE;
          idx_nx   = '0;
          nib_nx   = '0;
          addr_nx  = BASE_ADDR;
          data_nx  = hex_ascii(words[31:28]);
          wen_nx   = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      S_WRITE: begin
        busy_nx = 1'b1;
        if (nib == 3'd7 && idx == LAST_I) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end else if (nib == 3'd7) begin
          wen_nx  = 1'b1;
          idx_nx  = idx_p1;
          nib_nx  = '0;
          addr_nx = display.w_addr + ROW_STEP;
          data_nx = hex_ascii(nxt_word[31:28]);
        end else begin
          wen_nx  = 1'b1;
          nib_nx  = nib_p1;
          addr_nx = display.w_addr + 12'd1;
          data_nx = hex_ascii(cur_sh[31:28]);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      nib            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      display.wen    <= 1'b0;
      display.w_addr <= '0;
      display.w_data <= '0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      nib            <= nib_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      display.wen    <= wen_nx;
      display.w_addr <= addr_nx;
      display.w_data <= data_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (snap_ld) begin
      for (int k = 0; k < NUM_WORDS; k++) snap[k] <= words[k*32 +: 32];
    end
  end

endmodule

// File: tb/tb_vga_hex_writer.sv
// Two writers (row stride 1 and 2) driven in lockstep and compared to a cell-list model.
module tb_vga_hex_writer;
  localparam int NW   = 2;
  localparam int ROW0 = 2;
  localparam int COL0 = 4;
  localparam int COLS = 80;
  localparam int NCH  = 8 * NW;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] words;
  logic        busy_a, done_a, busy_b, done_b;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  vga_hex_writer_if disp_a ();
  vga_hex_writer_if disp_b ();

  vga_hex_writer #(.NUM_WORDS(NW), .ROW0(ROW0), .COL0(COL0), .ROW_STRIDE(1), .COLS(COLS)) dut_a (
    .clk(clk), .rst(rst), .start(start), .words(words),
    .busy(busy_a), .done(done_a), .display(disp_a.master));

  vga_hex_writer #(.NUM_WORDS(NW), .ROW0(ROW0), .COL0(COL0), .ROW_STRIDE(2), .COLS(COLS)) dut_b (
    .clk(clk), .rst(rst), .start(start), .words(words),
    .busy(busy_b), .done(done_b), .display(disp_b.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Cell k of a pass: word k/8, digit k%8 counted from the most significant end.
  function automatic int exp_addr(input int stride, input int k);
    return (ROW0 + (k / 8) * stride) * COLS + COL0 + (k % 8);
  endfunction

  function automatic logic [7:0] exp_char(input logic [31:0] w0, input logic [31:0] w1, input int k);
    logic [31:0] w;
    int v;
    w = (k < 8) ? w0 : w1;
    v = int'((w >> (4 * (7 - (k % 8)))) & 32'hF);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  task automatic chk_idle_outputs(input bit after_reset);
    chk("wen_a", {31'd0, disp_a.wen}, 0);
    chk("wen_b", {31'd0, disp_b.wen}, 0);
    chk("busy_a", {31'd0, busy_a}, 0);
    chk("busy_b", {31'd0, busy_b}, 0);
    chk("done_a", {31'd0, done_a}, 0);
    chk("done_b", {31'd0, done_b}, 0);
    if (after_reset) begin
      chk("rst_addr_a", {20'd0, disp_a.w_addr}, 0);
      chk("rst_data_b", {24'd0, disp_b.w_data}, 0);
    end
  endtask

  // Starts a pass from the current cycle; returns in the idle cycle after DONE,
  // or in the cycle after a reset when abort_at is nonzero.
  task automatic run_pass(input logic [31:0] w0, input logic [31:0] w1,
                          input bit glitch, input int abort_at);
    int c;
    bit wexp;
    words = {w1, w0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 1; c <= NCH + 1; c++) begin
      cyc  = c;
      wexp = (c <= NCH);
      chk("wen_a", {31'd0, disp_a.wen}, {31'd0, wexp});
      chk("wen_b", {31'd0, disp_b.wen}, {31'd0, wexp});
      chk("busy_a", {31'd0, busy_a}, 1);
      chk("busy_b", {31'd0, busy_b}, 1);
      chk("done_a", {31'd0, done_a}, {31'd0, !wexp});
      chk("done_b", {31'd0, done_b}, {31'd0, !wexp});
      if (wexp) begin
        chk("addr_a", {20'd0, disp_a.w_addr}, exp_addr(1, c - 1));
        chk("addr_b", {20'd0, disp_b.w_addr}, exp_addr(2, c - 1));
        chk("data_a", {24'd0, disp_a.w_data}, {24'd0, exp_char(w0, w1, c - 1)});
        chk("data_b", {24'd0, disp_b.w_data}, {24'd0, exp_char(w0, w1, c - 1)});
      end else begin
        chk("hold_addr_a", {20'd0, disp_a.w_addr}, exp_addr(1, NCH - 1));
        chk("hold_data_b", {24'd0, disp_b.w_data}, {24'd0, exp_char(w0, w1, NCH - 1)});
      end
      if (abort_at != 0 && c == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = c + 1;
        chk_idle_outputs(1'b1);
        return;
      end
      if (glitch && c == 2) words[31:0] = 32'hFFFF_FFFF;
      start = glitch && (c == 5 || c == NCH + 1);
      tick();
      start = 1'b0;
    end
    cyc = NCH + 2;
    chk_idle_outputs(1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    words = '0;
    tick();
    cyc = 0;
    chk_idle_outputs(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle_outputs(1'b1);
    rst = 1'b0;

    for (int k = 0; k < 100; k++) begin
      tick();
      cyc = k;
      chk_idle_outputs(1'b0);
    end

    // Snapshot and ignored starts (WRITE and DONE), then an immediate back-to-back pass.
    run_pass(32'h1234_ABCD, 32'hDEAD_BEEF, 1'b1, 0);
    run_pass(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 0);

    // Reset mid-pass, one idle cycle, then a clean restart.
    run_pass(32'hCAFE_F00D, 32'h0BAD_5EED, 1'b0, 5);
    tick();
    cyc = 7;
    chk_idle_outputs(1'b1);
    run_pass(32'h1234_ABCD, 32'hDEAD_BEEF, 1'b0, 0);

    for (int p = 0; p < 12; p++) begin
      run_pass($urandom, $urandom, p[0], (p % 5 == 3) ? int'($urandom_range(1, NCH + 1)) : 0);
      if (p % 3 == 2) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) tick();
        chk_idle_outputs(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
